branch_resolve_unit: RTL and testbench

In-order tracker of in-flight branch predictions, sitting between ID (enqueue) and EX (resolve). It holds each decoded control-flow instruction's predicted direction and target. When the instruction resolves in EX, the unit compares actual against predicted and drives the training port of the 2-bit-counter predictor (`update_enable`, `pc_update`, `branch_taken`, `is_branch`). It also raises a registered mispredict/redirect to IF and squashes all younger tracked entries.

---
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order tracker of in-flight branch predictions between ID and EX
//
// Holds {pc, pred_taken, pred_target} for each decoded control-flow instruction in a
// circular FIFO. When EX resolves the oldest entry, the unit emits a one-cycle training
// pulse for the 2-bit-counter predictor. On a misprediction it also emits a one-cycle
// redirect to IF and squashes every younger entry.
//
// Optional build macro: BRU_PERF_COUNTERS_EN adds o_perf_resolved / o_perf_mispredicted.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_enq_*               ID enqueue: valid, pc, predicted direction, predicted target
//   o_enq_ready           queue not full; ID stalls when low
//   i_res_*               EX resolve: valid, pc, conditional flag, actual direction/target
//   i_flush               trap squash: clears queue, drops enqueue, suppresses redirect
//   o_update_enable       predictor training strobe (with o_pc_update, o_branch_taken, o_is_branch)
//   o_mispredict          one-cycle redirect pulse, o_redirect_pc = correct next PC
//   o_order_error         sticky: resolve on empty queue or resolve PC != head PC
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_enq_valid,
    input  logic [XLEN-1:0] i_enq_pc,
    input  logic            i_enq_pred_taken,
    input  logic [XLEN-1:0] i_enq_pred_target,
    output logic            o_enq_ready,
    input  logic            i_res_valid,
    input  logic [XLEN-1:0] i_res_pc,
    input  logic            i_res_is_cond,
    input  logic            i_res_taken,
    input  logic [XLEN-1:0] i_res_target,
    input  logic            i_flush,
    output logic            o_update_enable,
    output logic [XLEN-1:0] o_pc_update,
    output logic            o_branch_taken,
    output logic            o_is_branch,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_order_error
`ifdef BRU_PERF_COUNTERS_EN
    ,
    output logic [31:0]     o_perf_resolved,
    output logic [31:0]     o_perf_mispredicted
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [XLEN-1:0] r_pc  [DEPTH];
    logic [XLEN-1:0] r_tgt [DEPTH];
    logic [DEPTH-1:0] r_pt;
    logic [AW:0] r_head, r_tail;

    logic            w_empty, w_full, w_enq, w_deq, w_mis, w_mis_out, w_order_err;
    logic [XLEN-1:0] w_head_pc, w_head_tgt;
    logic            w_head_pt;

    assign w_head_pc   = r_pc[r_head[AW-1:0]];
    assign w_head_tgt  = r_tgt[r_head[AW-1:0]];
    assign w_head_pt   = r_pt[r_head[AW-1:0]];
    assign w_empty     = r_head == r_tail;
    assign w_full      = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
    assign o_enq_ready = !w_full;
    assign w_deq       = i_res_valid && !w_empty;
    assign w_mis       = w_deq && ((i_res_taken != w_head_pt) ||
                                   (i_res_taken && (i_res_target != w_head_tgt)));
    assign w_mis_out   = w_mis && !i_flush;
    // A same-cycle enqueue is younger than the resolving branch, so it is wrong-path on a squash.
    assign w_enq       = i_enq_valid && !w_full && !i_flush && !w_mis;
    assign w_order_err = i_res_valid && (w_empty || (i_res_pc != w_head_pc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush || w_mis) begin
            r_head <= r_tail;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_ONE;
            if (w_deq) r_head <= r_head + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_tail[AW-1:0]]  <= i_enq_pc;
            r_tgt[r_tail[AW-1:0]] <= i_enq_pred_target;
            r_pt[r_tail[AW-1:0]]  <= i_enq_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_update_enable <= 1'b0;
            o_pc_update     <= '0;
            o_branch_taken  <= 1'b0;
            o_is_branch     <= 1'b0;
            o_mispredict    <= 1'b0;
            o_redirect_pc   <= '0;
            o_order_error   <= 1'b0;
        end else begin
            o_update_enable <= w_deq;
            o_mispredict    <= w_mis_out;
            if (w_deq) begin
                o_pc_update    <= i_res_pc;
                o_branch_taken <= i_res_taken;
                o_is_branch    <= i_res_is_cond;
            end
            if (w_mis_out) o_redirect_pc <= i_res_taken ? i_res_target : w_head_pc + XLEN'(4);
            if (w_order_err) o_order_error <= 1'b1;
        end
    end

`ifdef BRU_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_perf_resolved     <= '0;
            o_perf_mispredicted <= '0;
        end else begin
            if (w_deq) o_perf_resolved <= o_perf_resolved + 32'd1;
            if (w_mis_out) o_perf_mispredicted <= o_perf_mispredicted + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_enq_valid, i_enq_pred_taken, o_enq_ready;
    logic [31:0] i_enq_pc, i_enq_pred_target;
    logic        i_res_valid, i_res_is_cond, i_res_taken, i_flush;
    logic [31:0] i_res_pc, i_res_target;
    logic        o_update_enable, o_branch_taken, o_is_branch, o_mispredict, o_order_error;
    logic [31:0] o_pc_update, o_redirect_pc;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .i_enq_valid(i_enq_valid), .i_enq_pc(i_enq_pc), .i_enq_pred_taken(i_enq_pred_taken),
        .i_enq_pred_target(i_enq_pred_target), .o_enq_ready(o_enq_ready),
        .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_is_cond(i_res_is_cond),
        .i_res_taken(i_res_taken), .i_res_target(i_res_target), .i_flush(i_flush),
        .o_update_enable(o_update_enable), .o_pc_update(o_pc_update),
        .o_branch_taken(o_branch_taken), .o_is_branch(o_is_branch),
        .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
        .o_order_error(o_order_error)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic        isb;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (o_update_enable) begin
            if (exp_q.size() == 0) check("spurious_train", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("pc_update", o_pc_update, e.pc);
                check("branch_taken", 32'(o_branch_taken), 32'(e.tk));
                check("is_branch", 32'(o_is_branch), 32'(e.isb));
                check("mispredict", 32'(o_mispredict), 32'(e.mis));
                if (e.mis) check("redirect_pc", o_redirect_pc, e.redir);
            end
        end else begin
            check("idle_mispredict", 32'(o_mispredict), 32'd0);
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                check("missing_train", 32'd0, 32'd1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_update_enable", 32'(o_update_enable), 32'd0);
        check("rst_mispredict", 32'(o_mispredict), 32'd0);
        check("rst_order_error", 32'(o_order_error), 32'd0);
        check("rst_enq_ready", 32'(o_enq_ready), 32'd1);
        check("rst_pc_update", o_pc_update, 32'd0);
        check("rst_redirect_pc", o_redirect_pc, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        i_enq_valid = 1'b1;
        i_enq_pc = pc;
        i_enq_pred_taken = pt;
        i_enq_pred_target = tgt;
        tick();
        i_enq_valid = 1'b0;
    endtask

    task automatic res(input logic [31:0] pc, input logic cond, input logic tk,
                       input logic [31:0] tgt, input logic tr, input logic mis,
                       input logic [31:0] redir);
        i_res_valid = 1'b1;
        i_res_pc = pc;
        i_res_is_cond = cond;
        i_res_taken = tk;
        i_res_target = tgt;
        if (tr) exp_q.push_back('{pc: pc, tk: tk, isb: cond, mis: mis, redir: redir});
        tick();
        i_res_valid = 1'b0;
    endtask

    initial begin
        i_enq_valid = 0; i_enq_pc = 0; i_enq_pred_taken = 0; i_enq_pred_target = 0;
        i_res_valid = 0; i_res_pc = 0; i_res_is_cond = 0; i_res_taken = 0; i_res_target = 0;
        i_flush = 0;
        do_reset();
        check("init_branch_taken", 32'(o_branch_taken), 32'd0);
        check("init_is_branch", 32'(o_is_branch), 32'd0);

        enq(32'h100, 1'b1, 32'h200);
        res(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        enq(32'h300, 1'b0, 32'h0);
        i_enq_valid = 1'b1; i_enq_pc = 32'h304; i_enq_pred_taken = 1'b1; i_enq_pred_target = 32'h500;
        res(32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        i_enq_valid = 1'b0;
        res(32'h304, 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        check("t1_order_error", 32'(o_order_error), 32'd0);
        res(32'h999, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t1_empty_order_error", 32'(o_order_error), 32'd1);

        do_reset();
        enq(32'h104, 1'b0, 32'h0);
        i_enq_valid = 1'b1; i_enq_pc = 32'h108; i_enq_pred_taken = 1'b0;
        res(32'h104, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80);
        i_enq_valid = 1'b0;
        res(32'h108, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t2_squash_order_error", 32'(o_order_error), 32'd1);

        do_reset();
        enq(32'h10, 1'b1, 32'h50);
        enq(32'h20, 1'b0, 32'h0);
        res(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14);
        check("t3_enq_ready", 32'(o_enq_ready), 32'd1);
        check("t3_order_error_before", 32'(o_order_error), 32'd0);
        res(32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t3_order_error", 32'(o_order_error), 32'd1);

        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h40 + 32'(4 * i), 1'b0, 32'h0);
        check("t4_full_enq_ready", 32'(o_enq_ready), 32'd0);
        i_enq_valid = 1'b1; i_enq_pc = 32'h50; i_enq_pred_taken = 1'b0;
        res(32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        i_enq_valid = 1'b0;
        check("t4_after_deq_enq_ready", 32'(o_enq_ready), 32'd1);
        for (int i = 1; i < 4; i++) res(32'h40 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t4_order_error", 32'(o_order_error), 32'd0);
        res(32'h50, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t4_dropped_order_error", 32'(o_order_error), 32'd1);

        do_reset();
        enq(32'h60, 1'b1, 32'h300);
        res(32'h60, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400);
        do_reset();

        enq(32'h70, 1'b0, 32'h0);
        enq(32'h74, 1'b0, 32'h0);
        enq(32'h78, 1'b0, 32'h0);
        i_flush = 1'b1;
        i_enq_valid = 1'b1; i_enq_pc = 32'h7c; i_enq_pred_taken = 1'b0;
        res(32'h70, 1'b1, 1'b1, 32'h90, 1'b1, 1'b0, 32'h0);
        i_flush = 1'b0;
        i_enq_valid = 1'b0;
        check("t6_enq_ready", 32'(o_enq_ready), 32'd1);
        check("t6_redirect_held", o_redirect_pc, 32'd0);
        res(32'h74, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t6_order_error", 32'(o_order_error), 32'd1);

        do_reset();
        enq(32'h200, 1'b0, 32'h0);
        res(32'h208, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t7_pc_mismatch_order_error", 32'(o_order_error), 32'd1);
        enq(32'h210, 1'b1, 32'h600);
        res(32'h210, 1'b1, 1'b1, 32'h604, 1'b1, 1'b1, 32'h604);
        enq(32'hFFFF_FFFC, 1'b1, 32'h10);
        res(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        tick();
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
